// File: rtl/mem_access_unit.sv
// MEM-stage data-bus master: decodes loads/stores, checks alignment, runs one
// req/addr_ok/data_ok transaction at a time and returns the extended load result.
module mem_access_unit #(
   parameter bit STORE_WAIT_DATA_OK = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        memen_i,
   input  logic [5:0]  op_i,
   input  logic [31:0] aluout_i,
   input  logic [31:0] rdata2_i,
   input  logic [7:0]  except_i,
   output logic        data_req_o,
   output logic        data_wr_o,
   output logic [1:0]  data_size_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_addr_ok_i,
   input  logic        data_data_ok_i,
   input  logic [31:0] data_rdata_i,
   output logic        stall_o,
   output logic [31:0] result_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] badvaddr_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t      state_reg, state_next;

   logic        is_load, is_store;
   logic [1:0]  size;
   logic        misaligned, access, no_exc, go, issue, posted, pend;
   logic        capture_en, req_int, stall_int;
   logic [5:0]  op_reg;
   logic [1:0]  addr_lo_reg;
   logic [31:0] rdata_reg;
   logic [31:0] wdata_rep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size     = 2'd2;
      case (op_i)
         6'h20, 6'h24: begin is_load  = 1'b1; size = 2'd0; end
         6'h21, 6'h25: begin is_load  = 1'b1; size = 2'd1; end
         6'h23:        begin is_load  = 1'b1; size = 2'd2; end
         6'h28:        begin is_store = 1'b1; size = 2'd0; end
         6'h29:        begin is_store = 1'b1; size = 2'd1; end
         6'h2B:        begin is_store = 1'b1; size = 2'd2; end
         default:      ;
      endcase
   end

   assign misaligned = ((size == 2'd1) & aluout_i[0]) |
                       ((size == 2'd2) & (aluout_i[1:0] != 2'b00));
   assign access     = memen_i & (is_load | is_store);
   assign no_exc     = (except_i == 8'd0);
   assign go         = access & ~misaligned & no_exc & ~flush_i;
   // A posted store still owed a data_ok holds off the next request.
   assign issue      = go & ~pend;
   assign posted     = is_store & ~STORE_WAIT_DATA_OK;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      capture_en = 1'b0;
      req_int    = 1'b0;
      stall_int  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            req_int   = issue;
            stall_int = go;
            if (issue) begin
               if (data_addr_ok_i) begin
                  state_next = posted ? S_DONE : S_WAIT;
               end else begin
                  state_next = S_REQ;
               end
            end
         end
         S_REQ: begin
            req_int   = 1'b1;
            stall_int = 1'b1;
            if (data_addr_ok_i) begin
               if (posted) begin
                  state_next = flush_i ? S_IDLE : S_DONE;
               end else begin
                  state_next = flush_i ? S_DRAIN : S_WAIT;
               end
            end else if (flush_i) begin
               state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            stall_int = 1'b1;
            if (data_data_ok_i) begin
               capture_en = ~flush_i;
               state_next = flush_i ? S_IDLE : S_DONE;
            end else if (flush_i) begin
               state_next = S_DRAIN;
            end
         end
         S_DONE: begin
            if (!stall_i) begin
               state_next = S_IDLE;
            end
         end
         S_DRAIN: begin
            stall_int = 1'b1;
            if (data_data_ok_i) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_reg      <= 6'd0;
         addr_lo_reg <= 2'd0;
         rdata_reg   <= 32'd0;
      end else begin
         if (state_reg == S_IDLE && issue) begin
            op_reg      <= op_i;
            addr_lo_reg <= aluout_i[1:0];
         end
         if (capture_en) begin
            rdata_reg <= data_rdata_i;
         end
      end
   end

   generate
      if (!STORE_WAIT_DATA_OK) begin : g_posted
         logic pend_reg;
         logic post_accept;
         assign post_accept = req_int & posted & data_addr_ok_i;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               pend_reg <= 1'b0;
            end else if (post_accept) begin
               pend_reg <= 1'b1;
            end else if (data_data_ok_i) begin
               pend_reg <= 1'b0;
            end
         end
         assign pend = pend_reg;
      end else begin : g_nonposted
         assign pend = 1'b0;
      end
   endgenerate

   // Store data replicated across every lane the access size can hit.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata_rep[8*gi +: 8] = (size == 2'd0) ? rdata2_i[7:0] :
                                       (size == 2'd1) ? rdata2_i[8*(gi%2) +: 8] :
                                                        rdata2_i[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      case (addr_lo_reg)
         2'd0:    byte_sel = rdata_reg[7:0];
         2'd1:    byte_sel = rdata_reg[15:8];
         2'd2:    byte_sel = rdata_reg[23:16];
         default: byte_sel = rdata_reg[31:24];
      endcase
      half_sel = addr_lo_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
      load_ext = 32'd0;
      case (op_reg)
         6'h20:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         6'h24:   load_ext = {24'd0, byte_sel};
         6'h21:   load_ext = {{16{half_sel[15]}}, half_sel};
         6'h25:   load_ext = {16'd0, half_sel};
         6'h23:   load_ext = rdata_reg;
         default: load_ext = 32'd0;
      endcase
   end

   assign result_o     = (state_reg == S_DONE) ? load_ext : 32'd0;

   // Outputs are forced low while reset is held, regardless of pipeline inputs.
   assign data_req_o   = rst_ni & req_int;
   assign data_wr_o    = data_req_o & is_store;
   assign data_size_o  = data_req_o ? size : 2'd0;
   assign data_addr_o  = data_req_o ? aluout_i : 32'd0;
   assign data_wdata_o = data_req_o ? wdata_rep : 32'd0;
   assign stall_o      = rst_ni & stall_int;
   assign adel_o       = rst_ni & memen_i & is_load & misaligned & no_exc;
   assign ades_o       = rst_ni & memen_i & is_store & misaligned & no_exc;
   assign badvaddr_o   = (adel_o | ades_o) ? aluout_i : 32'd0;

endmodule
